// File: rtl/ibex_alu_pext_dw_seq.sv
// Sequencer for 64-bit Pext add/sub over register pairs: two passes on the shared 32-bit adder,
// then a halving/saturation fix-up and two handshaked 32-bit write-back beats.
module ibex_alu_pext_dw_seq (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [3:0]  op_i,
  input  logic [63:0] op_a_i,
  input  logic [63:0] op_b_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        adder_req_o,
  input  logic        adder_gnt_i,
  output logic [31:0] adder_a_o,
  output logic [31:0] adder_b_o,
  output logic        adder_cin_o,
  input  logic [31:0] adder_sum_i,
  input  logic        adder_cout_i,
  output logic        res_valid_o,
  input  logic        res_ready_i,
  output logic        res_hi_o,
  output logic [31:0] res_o,
  output logic        ov_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LO    = 3'd1,
    S_HI    = 3'd2,
    S_FIX   = 3'd3,
    S_WB_LO = 3'd4,
    S_WB_HI = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q;
  logic [63:0] a_q, b_q, res_q;
  logic [31:0] lo_q, hi_q;
  logic        c_q, bit64_q;

  logic        sub_s, uns_s;
  logic [1:0]  mode_s;
  logic [31:0] b_lo_s, b_hi_s;
  logic        bit64_s;
  logic [64:0] r_s;
  logic [63:0] fix_s;
  logic        sat_s;

  assign sub_s  = op_q[0];
  assign mode_s = op_q[2:1];
  assign uns_s  = op_q[3];
  assign b_lo_s = sub_s ? ~b_q[31:0]  : b_q[31:0];
  assign b_hi_s = sub_s ? ~b_q[63:32] : b_q[63:32];
  // Bit 64 of the exact result: sign extension for signed ops, carry/not-borrow for unsigned.
  assign bit64_s = uns_s ? (sub_s ? ~adder_cout_i : adder_cout_i)
                         : (a_q[63] ^ b_hi_s[31] ^ adder_cout_i);
  assign r_s = {bit64_q, hi_q, lo_q};

  // Halving / saturation fix-up of the 65-bit exact result.
  always_comb begin
    fix_s = r_s[63:0];
    sat_s = 1'b0;
    case (mode_s)
      2'b01: begin
        fix_s = r_s[64:1];
      end
      2'b10: begin
        if (uns_s) begin
          if (r_s[64]) begin
            fix_s = sub_s ? 64'h0000_0000_0000_0000 : 64'hFFFF_FFFF_FFFF_FFFF;
            sat_s = 1'b1;
          end else begin
            fix_s = r_s[63:0];
          end
        end else begin
          if (r_s[64] != r_s[63]) begin
            fix_s = r_s[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
            sat_s = 1'b1;
          end else begin
            fix_s = r_s[63:0];
          end
        end
      end
      default: begin
        fix_s = r_s[63:0];
      end
    endcase
  end

  // Next-state and output decode; flush overrides everything.
  always_comb begin
    state_d     = state_q;
    busy_o      = (state_q != S_IDLE);
    adder_req_o = 1'b0;
    adder_a_o   = 32'h0000_0000;
    adder_b_o   = 32'h0000_0000;
    adder_cin_o = 1'b0;
    res_valid_o = 1'b0;
    res_hi_o    = 1'b0;
    res_o       = 32'h0000_0000;
    ov_o        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LO: begin
        adder_req_o = 1'b1;
        adder_a_o   = a_q[31:0];
        adder_b_o   = b_lo_s;
        adder_cin_o = sub_s;
        if (adder_gnt_i) begin
          state_d = S_HI;
        end else begin
          state_d = S_LO;
        end
      end
      S_HI: begin
        adder_req_o = 1'b1;
        adder_a_o   = a_q[63:32];
        adder_b_o   = b_hi_s;
        adder_cin_o = c_q;
        if (adder_gnt_i) begin
          state_d = S_FIX;
        end else begin
          state_d = S_HI;
        end
      end
      S_FIX: begin
        ov_o    = sat_s;
        state_d = S_WB_LO;
      end
      S_WB_LO: begin
        res_valid_o = 1'b1;
        res_o       = res_q[31:0];
        if (res_ready_i) begin
          state_d = S_WB_HI;
        end else begin
          state_d = S_WB_LO;
        end
      end
      S_WB_HI: begin
        res_valid_o = 1'b1;
        res_hi_o    = 1'b1;
        res_o       = res_q[63:32];
        if (res_ready_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_WB_HI;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (flush_i) begin
      state_d     = S_IDLE;
      adder_req_o = 1'b0;
      res_valid_o = 1'b0;
      ov_o        = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch, per-pass adder captures and fixed-up result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q    <= 4'h0;
      a_q     <= 64'h0000_0000_0000_0000;
      b_q     <= 64'h0000_0000_0000_0000;
      lo_q    <= 32'h0000_0000;
      hi_q    <= 32'h0000_0000;
      c_q     <= 1'b0;
      bit64_q <= 1'b0;
      res_q   <= 64'h0000_0000_0000_0000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !flush_i) begin
            op_q <= op_i;
            a_q  <= op_a_i;
            b_q  <= op_b_i;
          end
        end
        S_LO: begin
          if (adder_gnt_i) begin
            lo_q <= adder_sum_i;
            c_q  <= adder_cout_i;
          end
        end
        S_HI: begin
          if (adder_gnt_i) begin
            hi_q    <= adder_sum_i;
            bit64_q <= bit64_s;
          end
        end
        S_FIX: begin
          res_q <= fix_s;
        end
        default: begin
          res_q <= res_q;
        end
      endcase
    end
  end

endmodule
